// File: rtl/mig_app_responder_if.sv
// MIG 7-series UI app interface bundle (command, write-data and read-data channels).
//   master : DRAM request controller side (drives commands and write data)
//   slave  : memory side (drives calibration, ready flags, read data, error flag)
interface mig_app_responder_if;
  logic         calib_done;
  logic         app_rdy;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [29:0]  app_addr;
  logic         app_wdf_rdy;
  logic         app_wdf_wren;
  logic [255:0] app_wdf_data;
  logic         app_wdf_end;
  logic [31:0]  app_wdf_mask;
  logic [255:0] app_rd_data;
  logic         app_rd_data_end;
  logic         app_rd_data_valid;
  logic         cmd_err;

  modport master (
    input  calib_done, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_end,
           app_rd_data_valid, cmd_err,
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data, app_wdf_end,
           app_wdf_mask
  );

  modport slave (
    output calib_done, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_end,
           app_rd_data_valid, cmd_err,
    input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data, app_wdf_end,
           app_wdf_mask
  );
endinterface

// File: rtl/mig_app_responder.sv
// Behavioural stand-in for the MIG 7-series UI (MIG core + DDR3) used in simulation and
// loopback builds. Block-RAM array of 256-bit words with calibration delay, optional
// periodic app_rdy stalls, a write-data FIFO, byte-masked writes and fixed-latency reads.
// Ports:
//   sys_clk : clock, rising edge
//   rst     : synchronous active-high reset
//   app     : UI app interface, slave side (all outputs registered)
module mig_app_responder #(
  parameter int unsigned AW           = 10,
  parameter int unsigned RD_LATENCY   = 4,
  parameter int unsigned CALIB_CYCLES = 64,
  parameter int unsigned STALL_PERIOD = 0,
  parameter int unsigned WDF_DEPTH    = 4
) (
  input  logic               sys_clk,
  input  logic               rst,
  mig_app_responder_if.slave app
);

  localparam int unsigned DW      = 256;
  localparam int unsigned MW      = DW / 8;
  localparam int unsigned NWORDS  = 1 << AW;
  localparam int unsigned PW      = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
  localparam int unsigned FCW     = $clog2(WDF_DEPTH + 1);
  localparam int unsigned CALW    = (CALIB_CYCLES > 0) ? $clog2(CALIB_CYCLES + 1) : 1;
  localparam int unsigned SPW     = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int unsigned SP_LAST = (STALL_PERIOD > 1) ? STALL_PERIOD - 1 : 0;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {S_CALIB, S_RUN, S_WAIT_WDATA} state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } wdf_beat_t;

  state_t            state, state_nxt;
  logic [CALW-1:0]   calib_cnt, calib_cnt_nxt;
  logic              calib_nxt;
  logic [SPW-1:0]    stall_cnt, stall_cnt_nxt;
  logic              stall_tick_nxt;
  logic              calib_done_q, app_rdy_q, wdf_rdy_q, cmd_err_q;

  wdf_beat_t         fifo_mem [WDF_DEPTH];
  logic [PW-1:0]     fifo_rd_ptr, fifo_wr_ptr;
  logic [FCW-1:0]    fifo_cnt, fifo_cnt_nxt;
  wdf_beat_t         wdf_in, fifo_head, wr_beat;

  logic [AW-1:0]     cmd_idx, wait_idx, wr_idx;
  logic              cmd_acc, wdf_acc, is_wr, is_rd, is_bad;
  logic              push, pop, mem_we;

  logic [DW-1:0]     mem [NWORDS];
  logic [DW-1:0]     rd_word;
  logic [DW-1:0]     rd_pipe [RD_LATENCY-1];
  logic [RD_LATENCY-1:0] rd_vld;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^{app.app_addr[29:AW+3], app.app_addr[2:0]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WDF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Calibration and stall counters, next values (the ready flags are registered
  // from these so they are valid in the same cycle as the state they describe).
  always_comb begin
    calib_cnt_nxt = calib_cnt;
    if (calib_cnt != CALW'(CALIB_CYCLES)) calib_cnt_nxt = calib_cnt + 1'b1;
    calib_nxt      = (calib_cnt_nxt == CALW'(CALIB_CYCLES));
    stall_cnt_nxt  = (stall_cnt == SPW'(SP_LAST)) ? '0 : stall_cnt + 1'b1;
    stall_tick_nxt = (STALL_PERIOD != 0) && (stall_cnt_nxt == '0);
  end

  // Handshake decode
  always_comb begin
    cmd_idx     = app.app_addr[AW+2:3];
    cmd_acc     = app.app_en && app_rdy_q;
    wdf_acc     = app.app_wdf_wren && wdf_rdy_q;
    is_wr       = cmd_acc && (app.app_cmd == CMD_WR);
    is_rd       = cmd_acc && (app.app_cmd == CMD_RD);
    is_bad      = cmd_acc && (app.app_cmd != CMD_WR) && (app.app_cmd != CMD_RD);
    wdf_in.data = app.app_wdf_data;
    wdf_in.mask = app.app_wdf_mask;
    fifo_head   = fifo_mem[fifo_rd_ptr];
  end

  // Next state and write-path steering
  always_comb begin
    state_nxt = state;
    push      = wdf_acc;
    pop       = 1'b0;
    mem_we    = 1'b0;
    wr_idx    = cmd_idx;
    wr_beat   = fifo_head;
    case (state)
      S_CALIB: begin
        if (calib_nxt) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (is_wr) begin
          if (fifo_cnt != '0) begin
            pop    = 1'b1;
            mem_we = 1'b1;
          end else if (wdf_acc) begin
            // empty FIFO: same-cycle beat goes straight to the array
            push    = 1'b0;
            mem_we  = 1'b1;
            wr_beat = wdf_in;
          end else begin
            state_nxt = S_WAIT_WDATA;
          end
        end
      end
      S_WAIT_WDATA: begin
        // FIFO is necessarily empty here, so the first beat completes the write
        if (wdf_acc) begin
          push      = 1'b0;
          mem_we    = 1'b1;
          wr_idx    = wait_idx;
          wr_beat   = wdf_in;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_CALIB;
    endcase
    fifo_cnt_nxt = fifo_cnt + FCW'(push) - FCW'(pop);
  end

  // Control registers
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= S_CALIB;
      calib_cnt    <= '0;
      stall_cnt    <= '0;
      calib_done_q <= 1'b0;
      app_rdy_q    <= 1'b0;
      wdf_rdy_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
      fifo_rd_ptr  <= '0;
      fifo_wr_ptr  <= '0;
      fifo_cnt     <= '0;
      wait_idx     <= '0;
      rd_vld       <= '0;
    end else begin
      state        <= state_nxt;
      calib_cnt    <= calib_cnt_nxt;
      stall_cnt    <= stall_cnt_nxt;
      calib_done_q <= calib_nxt;
      app_rdy_q    <= (state_nxt == S_RUN) && !stall_tick_nxt;
      wdf_rdy_q    <= calib_nxt && (fifo_cnt_nxt != FCW'(WDF_DEPTH));
      cmd_err_q    <= cmd_err_q || is_bad || (wdf_acc && !app.app_wdf_end);
      fifo_cnt     <= fifo_cnt_nxt;
      if (push) fifo_wr_ptr <= ptr_inc(fifo_wr_ptr);
      if (pop)  fifo_rd_ptr <= ptr_inc(fifo_rd_ptr);
      if ((state == S_RUN) && (state_nxt == S_WAIT_WDATA)) wait_idx <= cmd_idx;
      rd_vld       <= {rd_vld[RD_LATENCY-2:0], is_rd};
    end
  end

  // Storage: FIFO entries, byte-masked array write, registered array read
  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[fifo_wr_ptr] <= wdf_in;
    if (mem_we && !rst) begin
      for (int b = 0; b < int'(MW); b++) begin
        if (!wr_beat.mask[b]) mem[wr_idx][8*b +: 8] <= wr_beat.data[8*b +: 8];
      end
    end
    if (is_rd) rd_word <= mem[cmd_idx];
  end

  // Read-data delay line, aligned with rd_vld
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LATENCY) - 1; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= rd_word;
      for (int i = 1; i < int'(RD_LATENCY) - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign app.calib_done        = calib_done_q;
  assign app.app_rdy           = app_rdy_q;
  assign app.app_wdf_rdy       = wdf_rdy_q;
  assign app.cmd_err           = cmd_err_q;
  assign app.app_rd_data       = rd_pipe[RD_LATENCY-2];
  assign app.app_rd_data_valid = rd_vld[RD_LATENCY-1];
  assign app.app_rd_data_end   = rd_vld[RD_LATENCY-1];

endmodule
